// File: rtl/bubble_dout_engine_pkg.sv
// bubble_pkg: shared FSM state type and access-type decode for the bubble DOUT engine.
package bubble_pkg;
    localparam int ACC_IDLE_BIT = 2;

    typedef enum logic [1:0] {IDLE, START, STREAM, STARVE} state_e;

    function automatic logic acc_active(input logic [2:0] acctype);
        return ~acctype[ACC_IDLE_BIT];
    endfunction
endpackage

// File: rtl/bubble_dout_engine_if.sv
// bubble_dout_if: loader/timing-generator side signals of the bubble DOUT engine.
interface bubble_dout_if #(
    parameter int CH    = 4,
    parameter int CYC_W = 13
);
    localparam int AW = 1 + CYC_W + $clog2(CH);

    logic [2:0]       ACCTYPE;
    logic [CYC_W-1:0] BOUTCYCLENUM;
    logic [1:0]       BOUTTICKS;
    logic             nSWAPEN;
    logic [CH-1:0]    CHEN;
    logic             nOUTBUFWCLKEN;
    logic [AW-2:0]    OUTBUFWADDR;
    logic             OUTBUFWDATA;
    logic             WDONE;
    logic [CH-1:0]    DOUT;
    logic             WBANK;
    logic             WBUSY;
    logic             UNDERRUN;

    modport master (
        output ACCTYPE, BOUTCYCLENUM, BOUTTICKS, nSWAPEN, CHEN,
        output nOUTBUFWCLKEN, OUTBUFWADDR, OUTBUFWDATA, WDONE,
        input  DOUT, WBANK, WBUSY, UNDERRUN
    );
    modport slave (
        input  ACCTYPE, BOUTCYCLENUM, BOUTTICKS, nSWAPEN, CHEN,
        input  nOUTBUFWCLKEN, OUTBUFWADDR, OUTBUFWDATA, WDONE,
        output DOUT, WBANK, WBUSY, UNDERRUN
    );
endinterface

// File: rtl/bubble_dout_engine_ram.sv
// bubble_page_ram: one 1-bit dual-port RAM per channel spanning both banks,
// single-bit channel-decoded write port and a registered CH-bit read port.
module bubble_page_ram #(
    parameter int CH    = 4,
    parameter int CYC_W = 13
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [$clog2(CH)-1:0] wch,
    input  logic [CYC_W:0]        waddr,
    input  logic                  wdata,
    input  logic                  re,
    input  logic [CYC_W:0]        raddr,
    output logic [CH-1:0]         rdata
);
    localparam int CHW   = $clog2(CH);
    localparam int DEPTH = 2 ** (CYC_W + 1);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic mem [DEPTH];
        logic rd_q, rd_d;
        always_comb rd_d = re ? mem[raddr] : rd_q;
        always_ff @(posedge clk) begin
            if (we && wch == CHW'(c)) mem[waddr] <= wdata;
            rd_q <= rd_d;
        end
        assign rdata[c] = rd_q;
    end
endmodule

// File: rtl/bubble_dout_engine.sv
// bubble_dout_engine: ping-pong page buffer streaming CH bubble DOUT channels,
// with bank handoff, pair swap, channel masking and sticky underrun reporting.
module bubble_dout_engine
    import bubble_pkg::*;
#(
    parameter int   CH       = 4,
    parameter int   CYC_W    = 13,
    parameter int   PAGE_CYC = 4096,
    parameter logic IDLE_LVL = 1'b1
) (
    input logic          MCLK,
    input logic          nRESET,
    bubble_dout_if.slave bus
);
    localparam int             CHW      = $clog2(CH);
    localparam logic [CYC_W:0] PAGE_LIM = (CYC_W + 1)'(PAGE_CYC);

    state_e        state_q, state_d;
    logic          rbank_q, rbank_d, swap_q, swap_d, under_q, under_d;
    logic          acc_idle_q, acc_idle_d, in_page_q, in_page_d;
    logic [1:0]    full_q, full_d, full_w, ticks_q, ticks_d;
    logic [CH-1:0] dout_q, dout_d, rdata;
    logic          wbank, active, start_swap, rd_ok, load, we;

    assign wbank      = ~rbank_q;
    assign active     = acc_active(bus.ACCTYPE);
    // WDONE is folded in combinationally so START and the end-of-stream handoff see it the same MCLK
    assign full_w     = full_q | (2'(bus.WDONE) << wbank);
    assign start_swap = full_w[wbank] & ~full_w[rbank_q];
    assign rd_ok      = full_w[rbank_q] | start_swap;
    assign load       = ticks_q == 2'd1 && bus.BOUTTICKS == 2'd2;
    assign we         = ~bus.nOUTBUFWCLKEN & ~full_q[wbank];

    bubble_page_ram #(.CH(CH), .CYC_W(CYC_W)) u_ram (
        .clk  (MCLK),
        .we   (we),
        .wch  (bus.OUTBUFWADDR[CHW-1:0]),
        .waddr({wbank, bus.OUTBUFWADDR[CYC_W+CHW-1:CHW]}),
        .wdata(bus.OUTBUFWDATA),
        .re   (bus.BOUTTICKS == 2'd1),
        .raddr({rbank_q, bus.BOUTCYCLENUM}),
        .rdata(rdata)
    );

    always_ff @(posedge MCLK or negedge nRESET)
        if (!nRESET) state_q <= IDLE;
        else         state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_idle_q && active) state_d = START;
            START:   state_d = rd_ok ? STREAM : STARVE;
            default: if (!active) state_d = IDLE;
        endcase
    end

    always_comb begin
        full_d  = full_w;
        rbank_d = rbank_q;
        swap_d  = swap_q;
        under_d = under_q;
        if (state_q == START) begin
            rbank_d = rbank_q ^ start_swap;
            swap_d  = ~bus.nSWAPEN;
            under_d = under_q | ~rd_ok;
        end else if (state_q == STREAM && !active) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = rbank_q ^ full_w[wbank];
        end
        acc_idle_d = ~active;
        ticks_d    = bus.BOUTTICKS;
        in_page_d  = bus.BOUTTICKS == 2'd1 ? {1'b0, bus.BOUTCYCLENUM} < PAGE_LIM : in_page_q;
        dout_d     = state_q != STREAM ? {CH{IDLE_LVL}} : dout_q;
        if (state_q == STREAM && load)
            for (int i = 0; i < CH; i++)
                dout_d[i] = bus.CHEN[i] && in_page_q ? rdata[swap_q ? i ^ 1 : i] : IDLE_LVL;
    end

    always_ff @(posedge MCLK or negedge nRESET)
        if (!nRESET) begin
            rbank_q    <= 1'b0;
            full_q     <= '0;
            swap_q     <= 1'b0;
            under_q    <= 1'b0;
            acc_idle_q <= 1'b1;
            ticks_q    <= '0;
            in_page_q  <= 1'b0;
            dout_q     <= {CH{IDLE_LVL}};
        end else begin
            rbank_q    <= rbank_d;
            full_q     <= full_d;
            swap_q     <= swap_d;
            under_q    <= under_d;
            acc_idle_q <= acc_idle_d;
            ticks_q    <= ticks_d;
            in_page_q  <= in_page_d;
            dout_q     <= dout_d;
        end

    assign bus.DOUT     = dout_q;
    assign bus.WBANK    = wbank;
    assign bus.WBUSY    = full_q[wbank];
    assign bus.UNDERRUN = under_q;
endmodule

// File: tb/tb_bubble_dout_engine.sv
// tb_bubble_dout_engine: table vectors, directed corner sequences and a randomized
// page/bank reference model for the bubble DOUT engine.
module tb_bubble_dout_engine;
    logic MCLK = 1'b0;
    logic nRESET = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bubble_dout_if #(.CH(4), .CYC_W(13)) bus ();
    bubble_dout_engine #(.CH(4), .CYC_W(13), .PAGE_CYC(4096), .IDLE_LVL(1'b1)) dut (
        .MCLK(MCLK), .nRESET(nRESET), .bus(bus)
    );

    always #5 MCLK = ~MCLK;

    // model: two page banks with full flags, a read-bank pointer and the latched access mode
    bit m_mem [2][8192][4];
    bit m_full [2];
    bit m_rb, m_stream, m_swap, m_under;

    typedef struct {
        int         grp;
        int         cyc;
        logic [3:0] chen;
        logic       nswap;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge MCLK);
        #1;
    endtask

    function automatic logic [3:0] m_dout(input int cyc, input logic [3:0] chen);
        logic [3:0] e;
        for (int i = 0; i < 4; i++)
            e[i] = (m_stream && chen[i] && cyc < 4096) ? m_mem[m_rb][cyc][m_swap ? i ^ 1 : i] : 1'b1;
        return e;
    endfunction

    task automatic m_reset;
        m_full   = '{default: 1'b0};
        m_rb     = 1'b0;
        m_stream = 1'b0;
        m_swap   = 1'b0;
        m_under  = 1'b0;
    endtask

    task automatic status(input string tag);
        chk({tag, " WBANK"}, 32'(bus.WBANK), 32'(!m_rb));
        chk({tag, " WBUSY"}, 32'(bus.WBUSY), 32'(m_full[!m_rb]));
        chk({tag, " UNDERRUN"}, 32'(bus.UNDERRUN), 32'(m_under));
    endtask

    task automatic write_bit(input int cyc, input int ch, input bit b);
        bus.nOUTBUFWCLKEN = 1'b0;
        bus.OUTBUFWADDR   = {13'(cyc), 2'(ch)};
        bus.OUTBUFWDATA   = b;
        tick;
        bus.nOUTBUFWCLKEN = 1'b1;
        if (!m_full[!m_rb]) m_mem[!m_rb][cyc][ch] = b;
    endtask

    task automatic fill_pattern;
        for (int c = 0; c < 17; c++) begin
            int cyc;
            cyc = c == 16 ? 4095 : c;
            for (int ch = 0; ch < 4; ch++)
                write_bit(cyc, ch, ch == 0 ? ~cyc[0] : ch == 1 ? cyc[0] : 1'b1);
        end
    endtask

    task automatic fill_random;
        for (int c = 0; c < 16; c++)
            for (int ch = 0; ch < 4; ch++)
                write_bit(c, ch, 1'($urandom));
    endtask

    task automatic do_wdone;
        bus.WDONE = 1'b1;
        tick;
        bus.WDONE = 1'b0;
        m_full[!m_rb] = 1'b1;
    endtask

    task automatic do_start(input bit nsw, input bit wd);
        bus.nSWAPEN = nsw;
        bus.ACCTYPE = 3'b011;
        tick;
        bus.WDONE = wd;
        tick;
        bus.WDONE = 1'b0;
        if (wd) m_full[!m_rb] = 1'b1;
        if (m_full[!m_rb] && !m_full[m_rb]) m_rb = !m_rb;
        m_swap   = !nsw;
        m_stream = m_full[m_rb];
        if (!m_stream) m_under = 1'b1;
    endtask

    task automatic do_end;
        bus.ACCTYPE = 3'b110;
        tick;
        tick;
        if (m_stream) begin
            m_full[m_rb] = 1'b0;
            if (m_full[!m_rb]) m_rb = !m_rb;
        end
        m_stream = 1'b0;
    endtask

    task automatic bit_cycle(input int cyc, input logic [3:0] chen, input bit nsw,
                             input logic [3:0] exp, input string tag);
        bus.BOUTCYCLENUM = 13'(cyc);
        bus.CHEN         = chen;
        bus.nSWAPEN      = nsw;
        bus.BOUTTICKS    = 2'd0;
        tick;
        tick;
        bus.BOUTTICKS = 2'd1;
        tick;
        tick;
        bus.BOUTTICKS = 2'd2;
        tick;
        chk($sformatf("%s DOUT cyc%0d", tag, cyc), 32'(bus.DOUT), 32'(exp));
        tick;
        bus.BOUTTICKS = 2'd3;
        tick;
        tick;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 0,    4'hF,    1'b1, 4'b1101};
        tbl[1]  = '{0, 1,    4'hF,    1'b1, 4'b1110};
        tbl[2]  = '{0, 2,    4'hF,    1'b0, 4'b1101};
        tbl[3]  = '{0, 7,    4'hF,    1'b1, 4'b1110};
        tbl[4]  = '{0, 4095, 4'hF,    1'b1, 4'b1110};
        tbl[5]  = '{0, 4096, 4'hF,    1'b1, 4'b1111};
        tbl[6]  = '{0, 8191, 4'hF,    1'b1, 4'b1111};
        tbl[7]  = '{0, 3,    4'b0101, 1'b1, 4'b1110};
        tbl[8]  = '{0, 6,    4'b0000, 1'b1, 4'b1111};
        tbl[9]  = '{1, 0,    4'hF,    1'b0, 4'b1110};
        tbl[10] = '{1, 1,    4'hF,    1'b1, 4'b1101};
        tbl[11] = '{1, 2,    4'hF,    1'b0, 4'b1110};
        tbl[12] = '{1, 5,    4'hF,    1'b1, 4'b1101};
        tbl[13] = '{1, 4,    4'b1110, 1'b0, 4'b1111};
        tbl[14] = '{1, 4096, 4'hF,    1'b0, 4'b1111};

        bus.ACCTYPE       = 3'b100;
        bus.BOUTCYCLENUM  = '0;
        bus.BOUTTICKS     = 2'd0;
        bus.nSWAPEN       = 1'b1;
        bus.CHEN          = 4'hF;
        bus.nOUTBUFWCLKEN = 1'b1;
        bus.OUTBUFWADDR   = '0;
        bus.OUTBUFWDATA   = 1'b0;
        bus.WDONE         = 1'b0;
        m_reset;
        repeat (3) tick;
        nRESET = 1'b1;
        tick;
        chk("reset DOUT", 32'(bus.DOUT), 32'hF);
        status("reset");

        // access with nothing loaded: underrun, idle outputs
        do_start(1'b1, 1'b0);
        status("starve");
        bit_cycle(0, 4'hF, 1'b1, m_dout(0, 4'hF), "starve");
        bit_cycle(1, 4'hF, 1'b1, m_dout(1, 4'hF), "starve");
        do_end;
        status("starve end");

        // pattern page, normal mode
        fill_pattern;
        status("pre wdone");
        do_wdone;
        status("wdone");
        do_start(1'b1, 1'b0);
        status("start1");
        for (int k = 0; k < 15; k++)
            if (tbl[k].grp == 0)
                bit_cycle(tbl[k].cyc, tbl[k].chen, tbl[k].nswap, tbl[k].exp, $sformatf("tbl%0d", k));

        // load the other bank while streaming, then try to corrupt it once full
        fill_random;
        do_wdone;
        status("wdone2");
        for (int c = 0; c < 16; c++) write_bit(c, c % 4, 1'($urandom));
        do_end;
        status("end1");
        do_start(1'b1, 1'b0);
        status("start2");
        for (int c = 0; c < 16; c++) bit_cycle(c, 4'hF, 1'b1, m_dout(c, 4'hF), "readback");
        do_end;

        // swap mode
        fill_pattern;
        do_wdone;
        do_start(1'b0, 1'b0);
        status("start swap");
        for (int k = 0; k < 15; k++)
            if (tbl[k].grp == 1)
                bit_cycle(tbl[k].cyc, tbl[k].chen, tbl[k].nswap, tbl[k].exp, $sformatf("tbl%0d", k));
        do_end;
        status("end swap");

        for (int r = 0; r < 8; r++) begin
            int  mode;
            bit  nsw;
            fill_random;
            mode = $urandom_range(0, 3);
            if (mode >= 2) do_wdone;
            nsw = 1'($urandom);
            do_start(nsw, mode == 1);
            status($sformatf("rnd%0d start", r));
            for (int b = 0; b < 10; b++) begin
                int         cyc;
                logic [3:0] chen;
                cyc  = $urandom_range(0, 5) == 0 ? 4096 + $urandom_range(0, 4095) : $urandom_range(0, 15);
                chen = 4'($urandom);
                bit_cycle(cyc, chen, 1'($urandom), m_dout(cyc, chen), $sformatf("rnd%0d", r));
            end
            do_end;
            status($sformatf("rnd%0d end", r));
        end

        // WDONE coinciding with START, masked channels, async reset mid-stream
        nRESET = 1'b0;
        m_reset;
        tick;
        nRESET = 1'b1;
        tick;
        status("reset2");
        fill_pattern;
        do_start(1'b1, 1'b1);
        status("bypass start");
        bit_cycle(0, 4'b0101, 1'b1, m_dout(0, 4'b0101), "mask");
        bit_cycle(1, 4'b0101, 1'b1, m_dout(1, 4'b0101), "mask");
        #2;
        nRESET = 1'b0;
        #1;
        chk("async reset DOUT", 32'(bus.DOUT), 32'hF);
        m_reset;
        bus.ACCTYPE = 3'b110;
        status("async reset");
        tick;
        nRESET = 1'b1;
        tick;
        bit_cycle(2, 4'hF, 1'b1, m_dout(2, 4'hF), "post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
